// File: rtl/pic_priority_ack_controller_if.sv
// Bundle of request, configuration, acknowledge and status signals between
// the configuration side / CPU side and the priority/acknowledge controller.
interface pic_priority_ack_controller_if;
    logic [7:0] ir;
    logic       ready_to_accept_interrupts_flag;
    logic       level_trigger_flag_and_edge_level_neg;
    logic [7:0] imr;
    logic [4:0] last_five_bits_of_vector_address;
    logic       aeoi_and_eoi_neg_flag;
    logic       automatic_rotation_mode_flag;
    logic [2:0] ir_level;
    logic [2:0] control_bits;
    logic       ocw2_output_flag;
    logic [1:0] read_type_flag;
    logic       inta_neg;
    logic       int_out;
    logic [7:0] vector_out;
    logic       vector_valid;
    logic [7:0] status_data;

    // Controller side
    modport slave (
        input  ir, ready_to_accept_interrupts_flag, level_trigger_flag_and_edge_level_neg,
               imr, last_five_bits_of_vector_address, aeoi_and_eoi_neg_flag,
               automatic_rotation_mode_flag, ir_level, control_bits, ocw2_output_flag,
               read_type_flag, inta_neg,
        output int_out, vector_out, vector_valid, status_data
    );

    // Driving side (configuration handler, request lines, CPU)
    modport master (
        output ir, ready_to_accept_interrupts_flag, level_trigger_flag_and_edge_level_neg,
               imr, last_five_bits_of_vector_address, aeoi_and_eoi_neg_flag,
               automatic_rotation_mode_flag, ir_level, control_bits, ocw2_output_flag,
               read_type_flag, inta_neg,
        input  int_out, vector_out, vector_valid, status_data
    );
endinterface

// File: rtl/pic_priority_ack_controller.sv
// PIC core: IRR/ISR/rotating priority, fully nested interrupt request to the
// CPU, two-pulse INTA acknowledge returning {base, level}, OCW2 EOI/rotation.
module pic_priority_ack_controller (
    input  logic                               clk,
    input  logic                               rst,
    pic_priority_ack_controller_if.slave       bus
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT2 = 1'b1;

    logic [7:0] r_irr;
    logic [7:0] r_isr;
    logic [2:0] r_lowest;
    logic [0:0] r_state;
    logic [7:0] r_ir_prev;
    logic       r_ocw2_prev;
    logic       r_inta_prev;
    logic [2:0] r_sel;
    logic       r_spurious;
    logic       r_int_out;
    logic [7:0] r_vector_out;
    logic       r_vector_valid;

    logic [7:0] w_cand;
    logic [3:0] w_cand_top;
    logic [3:0] w_isr_top;
    logic       w_req;
    logic       w_inta_fall;
    logic       w_ocw2_cmd;
    logic       w_ack1;
    logic       w_ack2;
    logic [7:0] w_edges;
    logic [7:0] w_ack_clr;
    logic [7:0] w_irr_n;
    logic [7:0] w_isr_n;
    logic [2:0] w_lowest_n;

    // Position in the rotating order: 0 = highest (lowest+1), 7 = lowest itself.
    function automatic logic [2:0] f_rank(input logic [2:0] lvl, input logic [2:0] lowest);
        return lvl - lowest - 3'd1;
    endfunction

    // Highest-priority set bit of mask as {found, level}; scanning from the
    // lowest-ranked slot upward lets the last hit be the winner.
    function automatic logic [3:0] f_top(input logic [7:0] mask, input logic [2:0] lowest);
        logic [3:0] res;
        logic [2:0] lvl;
        res = 4'd0;
        for (int k = 8; k >= 1; k--) begin
            lvl = lowest + 3'(k);
            if (mask[lvl]) res = {1'b1, lvl};
        end
        return res;
    endfunction

    // Priority resolution, event detection and next IRR/ISR/pointer values
    always_comb begin
        w_cand      = r_irr & ~bus.imr;
        w_cand_top  = f_top(w_cand, r_lowest);
        w_isr_top   = f_top(r_isr, r_lowest);
        w_req       = w_cand_top[3] &&
                      (!w_isr_top[3] || (f_rank(w_cand_top[2:0], r_lowest) < f_rank(w_isr_top[2:0], r_lowest)));
        w_inta_fall = r_inta_prev & ~bus.inta_neg;
        w_ocw2_cmd  = bus.ocw2_output_flag ^ r_ocw2_prev;
        w_ack1      = (r_state == ST_IDLE)  && w_inta_fall;
        w_ack2      = (r_state == ST_WAIT2) && w_inta_fall;
        w_edges     = bus.ir & ~r_ir_prev;

        // EOI clears act on the pre-edge ISR; the INTA set is applied last so it wins
        w_isr_n    = r_isr;
        w_lowest_n = r_lowest;
        if (w_ocw2_cmd) begin
            case (bus.control_bits)
                3'b001: if (w_isr_top[3]) w_isr_n[w_isr_top[2:0]] = 1'b0;
                3'b011: w_isr_n[bus.ir_level] = 1'b0;
                3'b101: if (w_isr_top[3]) begin
                            w_isr_n[w_isr_top[2:0]] = 1'b0;
                            w_lowest_n = w_isr_top[2:0];
                        end
                3'b111: begin
                            w_isr_n[bus.ir_level] = 1'b0;
                            w_lowest_n = bus.ir_level;
                        end
                3'b110: w_lowest_n = bus.ir_level;
                default: ;
            endcase
        end
        // Automatic EOI on the second pulse; its rotation overrides any OCW2 rotation
        if (w_ack2 && bus.aeoi_and_eoi_neg_flag && !r_spurious) begin
            w_isr_n[r_sel] = 1'b0;
            if (bus.automatic_rotation_mode_flag) w_lowest_n = r_sel;
        end
        if (w_ack1 && w_cand_top[3]) w_isr_n[w_cand_top[2:0]] = 1'b1;

        // A fresh edge capture beats the acknowledge clear on the same bit
        w_ack_clr = 8'd0;
        if (w_ack1 && w_cand_top[3]) w_ack_clr[w_cand_top[2:0]] = 1'b1;
        if (bus.level_trigger_flag_and_edge_level_neg)
            w_irr_n = bus.ir & ~w_ack_clr;
        else
            w_irr_n = (r_irr & ~w_ack_clr) | w_edges;
    end

    // OCW2 and INTA edge trackers follow their inputs every cycle, reset included
    always_ff @(posedge clk) begin
        r_ocw2_prev <= bus.ocw2_output_flag;
        r_inta_prev <= bus.inta_neg;
    end

    // Main state: registers, acknowledge FSM and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irr          <= 8'd0;
            r_isr          <= 8'd0;
            r_lowest       <= 3'd7;
            r_state        <= ST_IDLE;
            r_ir_prev      <= 8'd0;
            r_int_out      <= 1'b0;
            r_vector_out   <= 8'd0;
            r_vector_valid <= 1'b0;
        end else if (!bus.ready_to_accept_interrupts_flag) begin
            // Reinitialisation: clear like reset but keep the last vector visible
            r_irr          <= 8'd0;
            r_isr          <= 8'd0;
            r_lowest       <= 3'd7;
            r_state        <= ST_IDLE;
            r_ir_prev      <= 8'd0;
            r_int_out      <= 1'b0;
            r_vector_valid <= 1'b0;
        end else begin
            r_irr          <= w_irr_n;
            r_isr          <= w_isr_n;
            r_lowest       <= w_lowest_n;
            r_ir_prev      <= bus.ir;
            r_int_out      <= 1'b0;
            r_vector_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_inta_fall) begin
                        r_sel      <= w_cand_top[3] ? w_cand_top[2:0] : 3'd7;
                        r_spurious <= ~w_cand_top[3];
                        r_state    <= ST_WAIT2;
                    end else begin
                        r_int_out  <= w_req;
                    end
                end
                default: begin
                    if (w_inta_fall) begin
                        r_vector_out   <= {bus.last_five_bits_of_vector_address, r_sel};
                        r_vector_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.int_out      = r_int_out;
    assign bus.vector_out   = r_vector_out;
    assign bus.vector_valid = r_vector_valid;
    assign bus.status_data  = (bus.read_type_flag >= 2'b10) ? r_isr : r_irr;

endmodule

// File: tb/tb_pic_priority_ack_controller.sv
// Bench for pic_priority_ack_controller: directed scenarios with literal
// expectations plus a randomized run against a behavioural model.
module tb_pic_priority_ack_controller;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pic_priority_ack_controller_if bus_if();

    pic_priority_ack_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Behavioural model state
    logic [7:0] m_irr, m_isr, m_irprev, m_vout;
    int         m_lp, m_sel;
    bit         m_wait, m_spur, m_int, m_vvld, m_ocwprev, m_intaprev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0 = served first, 7 = the lowest-priority level itself
    function automatic int rank(input int lvl, input int lp);
        return (lvl - lp + 15) % 8;
    endfunction

    function automatic int top(input logic [7:0] m, input int lp);
        int best = -1;
        for (int l = 0; l < 8; l++)
            if (m[l] && (best < 0 || rank(l, lp) < rank(best, lp))) best = l;
        return best;
    endfunction

    // Reference model advanced on every rising edge
    always @(posedge clk) begin
        int tc, ti;
        logic [7:0] cand, edges, n_irr, n_isr;
        int n_lp;
        bit fall, req;
        if (rst) begin
            m_irr = 0; m_isr = 0; m_lp = 7; m_wait = 0; m_int = 0;
            m_vout = 0; m_vvld = 0; m_irprev = 0;
        end else if (!bus_if.ready_to_accept_interrupts_flag) begin
            m_irr = 0; m_isr = 0; m_lp = 7; m_wait = 0; m_int = 0;
            m_vvld = 0; m_irprev = 0;
        end else begin
            cand = m_irr & ~bus_if.imr;
            tc = top(cand, m_lp);
            ti = top(m_isr, m_lp);
            req = (tc >= 0) && (ti < 0 || rank(tc, m_lp) < rank(ti, m_lp));
            fall = m_intaprev && !bus_if.inta_neg;
            n_isr = m_isr;
            n_lp = m_lp;
            if (bus_if.ocw2_output_flag != m_ocwprev) begin
                case (bus_if.control_bits)
                    3'b001: if (ti >= 0) n_isr[ti] = 0;
                    3'b011: n_isr[bus_if.ir_level] = 0;
                    3'b101: if (ti >= 0) begin n_isr[ti] = 0; n_lp = ti; end
                    3'b111: begin n_isr[bus_if.ir_level] = 0; n_lp = bus_if.ir_level; end
                    3'b110: n_lp = bus_if.ir_level;
                    default: ;
                endcase
            end
            edges = bus_if.ir & ~m_irprev;
            n_irr = bus_if.level_trigger_flag_and_edge_level_neg ? bus_if.ir : (m_irr | edges);
            m_int = 0;
            m_vvld = 0;
            if (!m_wait) begin
                if (fall) begin
                    if (tc < 0) begin
                        m_sel = 7; m_spur = 1;
                    end else begin
                        m_sel = tc; m_spur = 0;
                        n_isr[tc] = 1;
                        if (bus_if.level_trigger_flag_and_edge_level_neg || !edges[tc]) n_irr[tc] = 0;
                    end
                    m_wait = 1;
                end else begin
                    m_int = req;
                end
            end else if (fall) begin
                m_vout = {bus_if.last_five_bits_of_vector_address, 3'(m_sel)};
                m_vvld = 1;
                if (bus_if.aeoi_and_eoi_neg_flag && !m_spur) begin
                    n_isr[m_sel] = 0;
                    if (bus_if.automatic_rotation_mode_flag) n_lp = m_sel;
                end
                m_wait = 0;
            end
            m_irr = n_irr; m_isr = n_isr; m_lp = n_lp;
            m_irprev = bus_if.ir;
        end
        m_ocwprev  = bus_if.ocw2_output_flag;
        m_intaprev = bus_if.inta_neg;
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk) begin
        if (chk_en) begin
            chk("int_out", 32'(bus_if.int_out), 32'(m_int));
            chk("vector_out", 32'(bus_if.vector_out), 32'(m_vout));
            chk("vector_valid", 32'(bus_if.vector_valid), 32'(m_vvld));
            chk("status_data", 32'(bus_if.status_data),
                32'(bus_if.read_type_flag[1] ? m_isr : m_irr));
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_reg(input string name, input bit sel_isr, input logic [7:0] exp);
        bus_if.read_type_flag = sel_isr ? 2'b10 : 2'b00;
        #1;
        chk(name, 32'(bus_if.status_data), 32'(exp));
    endtask

    task automatic pulse(input logic [7:0] m);
        bus_if.ir = m;
        cyc(1);
        bus_if.ir = 8'd0;
        cyc(1);
    endtask

    task automatic ack(output logic [7:0] vec, output logic vv);
        bus_if.inta_neg = 0; cyc(1);
        bus_if.inta_neg = 1; cyc(1);
        bus_if.inta_neg = 0; cyc(1);
        vec = bus_if.vector_out;
        vv  = bus_if.vector_valid;
        bus_if.inta_neg = 1; cyc(1);
    endtask

    task automatic ocw(input logic [2:0] cb, input logic [2:0] lvl);
        bus_if.control_bits = cb;
        bus_if.ir_level = lvl;
        bus_if.ocw2_output_flag = ~bus_if.ocw2_output_flag;
        cyc(1);
    endtask

    initial begin
        logic [7:0] vec;
        logic vv;
        rst = 1;
        bus_if.ir = 0;
        bus_if.ready_to_accept_interrupts_flag = 1;
        bus_if.level_trigger_flag_and_edge_level_neg = 0;
        bus_if.imr = 0;
        bus_if.last_five_bits_of_vector_address = 5'b01000;
        bus_if.aeoi_and_eoi_neg_flag = 0;
        bus_if.automatic_rotation_mode_flag = 0;
        bus_if.ir_level = 0;
        bus_if.control_bits = 0;
        bus_if.ocw2_output_flag = 0;
        bus_if.read_type_flag = 0;
        bus_if.inta_neg = 1;
        cyc(1);
        chk_en = 1;
        cyc(1);
        rst = 0;
        chk("rst int_out", 32'(bus_if.int_out), 0);
        chk("rst vector_out", 32'(bus_if.vector_out), 0);
        chk("rst vector_valid", 32'(bus_if.vector_valid), 0);
        chk_reg("rst irr", 0, 8'h00);

        // Single edge request on IR3
        bus_if.ir = 8'h08;
        cyc(1);
        chk_reg("ir3 irr", 0, 8'h08);
        chk("ir3 int_out early", 32'(bus_if.int_out), 0);
        bus_if.ir = 0;
        cyc(1);
        chk("ir3 int_out", 32'(bus_if.int_out), 1);
        bus_if.inta_neg = 0; cyc(1);
        chk("ir3 int_out after inta", 32'(bus_if.int_out), 0);
        chk_reg("ir3 isr", 1, 8'h08);
        chk_reg("ir3 irr cleared", 0, 8'h00);
        bus_if.inta_neg = 1; cyc(1);
        bus_if.inta_neg = 0; cyc(1);
        chk("ir3 vector", 32'(bus_if.vector_out), 32'h43);
        chk("ir3 valid", 32'(bus_if.vector_valid), 1);
        bus_if.inta_neg = 1; cyc(1);
        chk("ir3 valid one cycle", 32'(bus_if.vector_valid), 0);
        ocw(3'b001, 0);
        chk_reg("eoi isr", 1, 8'h00);

        // Fully nested
        pulse(8'h20);
        ack(vec, vv);
        chk("ir5 vector", 32'(vec), 32'h45);
        chk_reg("ir5 isr", 1, 8'h20);
        pulse(8'h04);
        chk("nested int_out", 32'(bus_if.int_out), 1);
        ack(vec, vv);
        chk("ir2 vector", 32'(vec), 32'h42);
        chk_reg("nested isr", 1, 8'h24);
        pulse(8'h40);
        chk("lower blocked", 32'(bus_if.int_out), 0);
        ocw(3'b001, 0);
        chk_reg("nseoi 1", 1, 8'h20);
        ocw(3'b001, 0);
        chk_reg("nseoi 2", 1, 8'h00);

        // Masking and spurious
        bus_if.imr = 8'hFF;
        cyc(2);
        chk("masked int_out", 32'(bus_if.int_out), 0);
        ack(vec, vv);
        chk("spurious vector", 32'(vec), 32'h47);
        chk("spurious valid", 32'(vv), 1);
        chk_reg("spurious isr", 1, 8'h00);
        chk_reg("spurious irr", 0, 8'h40);
        bus_if.ready_to_accept_interrupts_flag = 0; cyc(1);
        bus_if.ready_to_accept_interrupts_flag = 1;
        chk_reg("reinit irr", 0, 8'h00);
        bus_if.imr = 0;

        // AEOI with automatic rotation
        bus_if.aeoi_and_eoi_neg_flag = 1;
        bus_if.automatic_rotation_mode_flag = 1;
        pulse(8'h50);
        ack(vec, vv);
        chk("aeoi ir4", 32'(vec), 32'h44);
        chk_reg("aeoi isr", 1, 8'h00);
        pulse(8'h01);
        ack(vec, vv);
        chk("rotated ir6 first", 32'(vec), 32'h46);
        ack(vec, vv);
        chk("then ir0", 32'(vec), 32'h40);
        bus_if.aeoi_and_eoi_neg_flag = 0;
        bus_if.automatic_rotation_mode_flag = 0;

        // Specific rotation commands
        ocw(3'b110, 3'd2);
        pulse(8'h0A);
        ack(vec, vv);
        chk("rot ir3 first", 32'(vec), 32'h43);
        chk_reg("rot isr", 1, 8'h08);
        ocw(3'b111, 3'd3);
        chk_reg("specific rotate isr", 1, 8'h00);
        ack(vec, vv);
        chk("after rotate ir1", 32'(vec), 32'h41);
        ocw(3'b011, 3'd1);
        chk_reg("specific eoi", 1, 8'h00);

        // Level mode, reset and reinit inside WAIT2
        bus_if.level_trigger_flag_and_edge_level_neg = 1;
        bus_if.ir = 8'h01;
        cyc(1);
        chk_reg("level irr", 0, 8'h01);
        cyc(1);
        chk("level int_out", 32'(bus_if.int_out), 1);
        bus_if.ir = 0;
        cyc(1);
        chk_reg("level drop irr", 0, 8'h00);
        cyc(1);
        chk("level drop int_out", 32'(bus_if.int_out), 0);
        bus_if.ir = 8'h01;
        cyc(2);
        bus_if.inta_neg = 0; cyc(1);
        bus_if.inta_neg = 1; rst = 1; cyc(1);
        rst = 0;
        chk("wait2 rst vector", 32'(bus_if.vector_out), 0);
        chk("wait2 rst valid", 32'(bus_if.vector_valid), 0);
        chk_reg("wait2 rst isr", 1, 8'h00);
        chk_reg("wait2 rst irr", 0, 8'h00);
        cyc(2);
        ack(vec, vv);
        chk("level vector", 32'(vec), 32'h40);
        bus_if.inta_neg = 0; cyc(1);
        bus_if.inta_neg = 1; bus_if.ready_to_accept_interrupts_flag = 0; cyc(1);
        bus_if.ready_to_accept_interrupts_flag = 1;
        chk("reinit vector held", 32'(bus_if.vector_out), 32'h40);
        chk("reinit valid", 32'(bus_if.vector_valid), 0);
        chk_reg("reinit isr", 1, 8'h00);
        cyc(2);

        // Randomized traffic against the model
        bus_if.level_trigger_flag_and_edge_level_neg = 0;
        bus_if.ir = 0;
        rst = 1; cyc(1); rst = 0;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus_if.ready_to_accept_interrupts_flag = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 3) == 0) bus_if.ir = 8'($urandom & $urandom);
            if ($urandom_range(0, 49) == 0) bus_if.imr = 8'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 399) == 0)
                bus_if.level_trigger_flag_and_edge_level_neg = ~bus_if.level_trigger_flag_and_edge_level_neg;
            if ($urandom_range(0, 99) == 0) bus_if.last_five_bits_of_vector_address = 5'($urandom);
            if ($urandom_range(0, 99) == 0) bus_if.aeoi_and_eoi_neg_flag = 1'($urandom);
            if ($urandom_range(0, 99) == 0) bus_if.automatic_rotation_mode_flag = 1'($urandom);
            if ($urandom_range(0, 14) == 0) begin
                bus_if.control_bits = 3'($urandom);
                bus_if.ir_level = 3'($urandom);
                bus_if.ocw2_output_flag = ~bus_if.ocw2_output_flag;
            end
            bus_if.read_type_flag = 2'($urandom);
            if ($urandom_range(0, 2) == 0) bus_if.inta_neg = ~bus_if.inta_neg;
            cyc(1);
        end
        rst = 0;
        cyc(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
